// File: rtl/morse_pkg.sv
// Shared constants for the Morse keyer: state encoding, code points and element/gap lengths.
package morse_pkg;

  localparam int unsigned ST_W   = 3;
  localparam int unsigned CODE_W = 6;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned PAT_W  = 5;
  localparam int unsigned UCNT_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_MARK     = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP_ELEM = 3'd2;
  localparam logic [ST_W-1:0] ST_GAP_CHAR = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP_WORD = 3'd4;

  localparam logic [CODE_W-1:0] CODE_SPACE     = 6'd36;
  localparam logic [CODE_W-1:0] CODE_MAX_VALID = 6'd36;

  localparam logic [UCNT_W-1:0] DOT_U      = 3'd1;
  localparam logic [UCNT_W-1:0] DASH_U     = 3'd3;
  localparam logic [UCNT_W-1:0] ELEM_GAP_U = 3'd1;
  localparam logic [UCNT_W-1:0] CHAR_GAP_U = 3'd3;
  localparam logic [UCNT_W-1:0] WORD_GAP_U = 3'd7;

  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } rom_entry_t;

  // Number of units the given state lasts; a mark's length depends on its dash flag.
  function automatic logic [UCNT_W-1:0] state_units(input logic [ST_W-1:0] st, input logic dash);
    logic [UCNT_W-1:0] u;
    u = DOT_U;
    case (st)
      ST_MARK:     u = dash ? DASH_U : DOT_U;
      ST_GAP_ELEM: u = ELEM_GAP_U;
      ST_GAP_CHAR: u = CHAR_GAP_U;
      ST_GAP_WORD: u = WORD_GAP_U;
      default:     u = DOT_U;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/morse_keyer_sequencer_if.sv
// Character handshake, speed select and keying outputs of the Morse keyer.
interface morse_keyer_sequencer_if;
  import morse_pkg::*;

  logic              char_valid;
  logic [CODE_W-1:0] char_code;
  logic              char_ready;
  logic [7:0]        unit_len;
  logic              key_out;
  logic              elem_dash;
  logic              busy;
  logic              code_err;

  modport master (output char_valid, char_code, unit_len,
                  input  char_ready, key_out, elem_dash, busy, code_err);
  modport slave  (input  char_valid, char_code, unit_len,
                  output char_ready, key_out, elem_dash, busy, code_err);
endinterface

// File: rtl/morse_rom.sv
// Character code to Morse element table; pattern is sent LSB first, 1 = dash.
module morse_rom
  import morse_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output rom_entry_t        o_entry_c
);

  function automatic rom_entry_t mk(input logic [LEN_W-1:0] len, input logic [PAT_W-1:0] pat);
    return '{valid: 1'b1, len: len, pattern: pat};
  endfunction

  always_comb begin
    o_entry_c = '0;
    if (i_code < CODE_MAX_VALID) begin
      case (i_code)
        6'd0:  o_entry_c = mk(3'd2, 5'b00010);
        6'd1:  o_entry_c = mk(3'd4, 5'b00001);
        6'd2:  o_entry_c = mk(3'd4, 5'b00101);
        6'd3:  o_entry_c = mk(3'd3, 5'b00001);
        6'd4:  o_entry_c = mk(3'd1, 5'b00000);
        6'd5:  o_entry_c = mk(3'd4, 5'b00100);
        6'd6:  o_entry_c = mk(3'd3, 5'b00011);
        6'd7:  o_entry_c = mk(3'd4, 5'b00000);
        6'd8:  o_entry_c = mk(3'd2, 5'b00000);
        6'd9:  o_entry_c = mk(3'd4, 5'b01110);
        6'd10: o_entry_c = mk(3'd3, 5'b00101);
        6'd11: o_entry_c = mk(3'd4, 5'b00010);
        6'd12: o_entry_c = mk(3'd2, 5'b00011);
        6'd13: o_entry_c = mk(3'd2, 5'b00001);
        6'd14: o_entry_c = mk(3'd3, 5'b00111);
        6'd15: o_entry_c = mk(3'd4, 5'b00110);
        6'd16: o_entry_c = mk(3'd4, 5'b01011);
        6'd17: o_entry_c = mk(3'd3, 5'b00010);
        6'd18: o_entry_c = mk(3'd3, 5'b00000);
        6'd19: o_entry_c = mk(3'd1, 5'b00001);
        6'd20: o_entry_c = mk(3'd3, 5'b00100);
        6'd21: o_entry_c = mk(3'd4, 5'b01000);
        6'd22: o_entry_c = mk(3'd3, 5'b00110);
        6'd23: o_entry_c = mk(3'd4, 5'b01001);
        6'd24: o_entry_c = mk(3'd4, 5'b01101);
        6'd25: o_entry_c = mk(3'd4, 5'b00011);
        6'd26: o_entry_c = mk(3'd5, 5'b11111);
        6'd27: o_entry_c = mk(3'd5, 5'b11110);
        6'd28: o_entry_c = mk(3'd5, 5'b11100);
        6'd29: o_entry_c = mk(3'd5, 5'b11000);
        6'd30: o_entry_c = mk(3'd5, 5'b10000);
        6'd31: o_entry_c = mk(3'd5, 5'b00000);
        6'd32: o_entry_c = mk(3'd5, 5'b00001);
        6'd33: o_entry_c = mk(3'd5, 5'b00011);
        6'd34: o_entry_c = mk(3'd5, 5'b00111);
        6'd35: o_entry_c = mk(3'd5, 5'b01111);
        default: o_entry_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/morse_keyer_sequencer.sv
// Turns accepted character codes into timed Morse keying with a latched unit timebase.
module morse_keyer_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned       CTR_W      = 24,
  parameter logic [CTR_W-1:0]  UNIT_COUNT = CTR_W'(2_500_000)
) (
  input  logic                    clk,
  input  logic                    reset,
  morse_keyer_sequencer_if.slave  bus
);

  logic [ST_W-1:0]   r_state, w_state_nxt;
  logic [CTR_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [CTR_W-1:0]  r_cmp,   w_cmp_nxt;
  logic [UCNT_W-1:0] r_ucnt,  w_ucnt_nxt;
  logic [LEN_W-1:0]  r_idx,   w_idx_nxt;
  logic [LEN_W-1:0]  r_len,   w_len_nxt;
  logic [PAT_W-1:0]  r_pat,   w_pat_nxt;
  logic              r_key,   w_key_nxt;
  logic              r_dash,  w_dash_nxt;
  logic              r_err,   w_err_nxt;

  rom_entry_t        w_rom;
  logic              w_tick;
  logic              w_done;
  logic [LEN_W-1:0]  w_idx_inc;

  morse_rom u_rom (
    .i_code    (bus.char_code),
    .o_entry_c (w_rom)
  );

  assign w_tick    = (r_state != ST_IDLE) && (r_cnt == r_cmp);
  assign w_done    = w_tick && ((r_ucnt + UCNT_W'(1)) == state_units(r_state, r_dash));
  assign w_idx_inc = r_idx + LEN_W'(1);

  // Next-state and datapath updates; the unit counter only advances outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmp_nxt   = r_cmp;
    w_ucnt_nxt  = r_ucnt;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_pat_nxt   = r_pat;
    w_key_nxt   = r_key;
    w_dash_nxt  = r_dash;
    w_err_nxt   = 1'b0;

    if (r_state != ST_IDLE) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + CTR_W'(1);
      if (w_tick) w_ucnt_nxt = r_ucnt + UCNT_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.char_valid) begin
          w_cmp_nxt  = (bus.unit_len == 8'd0) ? UNIT_COUNT
                                              : CTR_W'({6'b0, bus.unit_len, 10'b0});
          w_cnt_nxt  = '0;
          w_ucnt_nxt = '0;
          w_idx_nxt  = '0;
          w_len_nxt  = w_rom.len;
          w_pat_nxt  = w_rom.pattern;
          if (w_rom.valid) begin
            w_state_nxt = ST_MARK;
            w_key_nxt   = 1'b1;
            w_dash_nxt  = w_rom.pattern[0];
          end else if (bus.char_code == CODE_SPACE) begin
            w_state_nxt = ST_GAP_WORD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (w_done) begin
          w_ucnt_nxt  = '0;
          w_key_nxt   = 1'b0;
          w_state_nxt = (r_idx < (r_len - LEN_W'(1))) ? ST_GAP_ELEM : ST_GAP_CHAR;
        end
      end
      ST_GAP_ELEM: begin
        if (w_done) begin
          w_ucnt_nxt  = '0;
          w_idx_nxt   = w_idx_inc;
          w_key_nxt   = 1'b1;
          w_dash_nxt  = r_pat[w_idx_inc];
          w_state_nxt = ST_MARK;
        end
      end
      ST_GAP_CHAR, ST_GAP_WORD: begin
        if (w_done) begin
          w_ucnt_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cmp   <= '0;
      r_ucnt  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_pat   <= '0;
      r_key   <= 1'b0;
      r_dash  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmp   <= w_cmp_nxt;
      r_ucnt  <= w_ucnt_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_pat   <= w_pat_nxt;
      r_key   <= w_key_nxt;
      r_dash  <= w_dash_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.char_ready = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.key_out    = r_key;
  assign bus.elem_dash  = r_dash;
  assign bus.code_err   = r_err;

endmodule

// File: tb/tb_morse_keyer_sequencer.sv
// Self-checking bench: keying waveforms compared against a dot/dash string model of Morse timing.
module tb_morse_keyer_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  morse_keyer_sequencer_if mi ();
  morse_keyer_sequencer_if zi ();

  morse_keyer_sequencer #(.CTR_W(24), .UNIT_COUNT(24'd3)) dut (
    .clk(clk), .reset(reset), .bus(mi.slave));
  morse_keyer_sequencer #(.CTR_W(24), .UNIT_COUNT(24'd0)) dut0 (
    .clk(clk), .reset(reset), .bus(zi.slave));

  string morse_tab [0:35] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  int exp_key[$];
  int exp_dash[$];

  function automatic logic o_ready(input int sel); return sel != 0 ? zi.char_ready : mi.char_ready; endfunction
  function automatic logic o_key  (input int sel); return sel != 0 ? zi.key_out    : mi.key_out;    endfunction
  function automatic logic o_dash (input int sel); return sel != 0 ? zi.elem_dash  : mi.elem_dash;  endfunction
  function automatic logic o_busy (input int sel); return sel != 0 ? zi.busy       : mi.busy;       endfunction
  function automatic logic o_err  (input int sel); return sel != 0 ? zi.code_err   : mi.code_err;   endfunction

  task automatic drive(input int sel, input logic v, input int code);
    if (sel != 0) begin zi.char_valid = v; zi.char_code = 6'(code); end
    else          begin mi.char_valid = v; mi.char_code = 6'(code); end
  endtask

  // Expected per-cycle key level and dash flag (-1 = don't care) for one character.
  task automatic build_expect(input int code, input int u);
    string s;
    int    d;
    exp_key.delete();
    exp_dash.delete();
    if (code == 36) begin
      repeat (7 * u) begin exp_key.push_back(0); exp_dash.push_back(-1); end
    end else begin
      s = morse_tab[code];
      for (int i = 0; i < s.len(); i++) begin
        d = (s[i] == "-") ? 1 : 0;
        repeat ((d != 0 ? 3 : 1) * u) begin exp_key.push_back(1); exp_dash.push_back(d); end
        if (i != s.len() - 1)
          repeat (u) begin exp_key.push_back(0); exp_dash.push_back(-1); end
      end
      repeat (3 * u) begin exp_key.push_back(0); exp_dash.push_back(-1); end
    end
  endtask

  // Sends one code and follows it cycle by cycle until the block is ready again.
  task automatic send_char(input int sel, input int code, input int u, input bit hold,
                           input int next_code, input int chg_cycle, input logic [7:0] chg_ul,
                           input string tag);
    int waited, n, key_bad, dash_bad, rdy_bad, first_bad;
    waited = 0;
    while (o_ready(sel) !== 1'b1 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (o_ready(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: char_ready=%b after %0d cycles, want 1", tag, o_ready(sel), waited);
    end
    drive(sel, 1'b1, code);
    @(posedge clk); #1;
    if (hold) drive(sel, 1'b1, next_code);
    else      drive(sel, 1'b0, 0);

    if (code > 36) begin
      checks++;
      if (o_err(sel) !== 1'b1 || o_ready(sel) !== 1'b1 || o_busy(sel) !== 1'b0 || o_key(sel) !== 1'b0) begin
        errors++;
        $display("FAIL %s invalid_accept: err=%b ready=%b busy=%b key=%b, want 1 1 0 0",
                 tag, o_err(sel), o_ready(sel), o_busy(sel), o_key(sel));
      end
      @(posedge clk); #1;
      checks++;
      if (o_err(sel) !== 1'b0 || o_key(sel) !== 1'b0 || o_busy(sel) !== 1'b0) begin
        errors++;
        $display("FAIL %s invalid_pulse_end: err=%b key=%b busy=%b, want 0 0 0",
                 tag, o_err(sel), o_key(sel), o_busy(sel));
      end
      return;
    end

    build_expect(code, u);
    n = exp_key.size();
    key_bad = 0; dash_bad = 0; rdy_bad = 0; first_bad = -1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == chg_cycle) mi.unit_len = chg_ul;
      if (o_key(sel) !== exp_key[k][0]) begin
        key_bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (exp_dash[k] >= 0 && o_dash(sel) !== exp_dash[k][0]) dash_bad++;
      if (o_ready(sel) !== 1'b0 || o_busy(sel) !== 1'b1) rdy_bad++;
    end
    checks++;
    if (key_bad != 0) begin
      errors++;
      $display("FAIL %s key_waveform: %0d wrong cycles of %0d, first at cycle %0d (got %b want %0d)",
               tag, key_bad, n, first_bad, o_key(sel), exp_key[first_bad < 0 ? 0 : first_bad]);
    end
    checks++;
    if (dash_bad != 0) begin
      errors++;
      $display("FAIL %s elem_dash: %0d wrong mark cycles, want 0", tag, dash_bad);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_window: %0d cycles with ready/busy wrong, want 0", tag, rdy_bad);
    end
    @(posedge clk); #1;
    checks++;
    if (o_ready(sel) !== 1'b1 || o_busy(sel) !== 1'b0 || o_key(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_return at cycle %0d: ready=%b busy=%b key=%b, want 1 0 0",
               tag, n, o_ready(sel), o_busy(sel), o_key(sel));
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 0); drive(1, 1'b0, 0);
    mi.unit_len = 8'd0; zi.unit_len = 8'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mi.key_out !== 1'b0 || mi.elem_dash !== 1'b0 || mi.busy !== 1'b0 || mi.code_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: key=%b dash=%b busy=%b err=%b, want 0 0 0 0",
               mi.key_out, mi.elem_dash, mi.busy, mi.code_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mi.char_ready !== 1'b1 || zi.char_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b/%b, want 1/1", mi.char_ready, zi.char_ready);
    end
  endtask

  task automatic test_letters();
    send_char(0, 4, 4, 1'b0, 0, -1, 8'd0, "E");
    send_char(0, 0, 4, 1'b0, 0, -1, 8'd0, "A");
  endtask

  task automatic test_back_to_back();
    send_char(0, 36, 4, 1'b1, 19, -1, 8'd0, "space_then_T");
    send_char(0, 19, 4, 1'b0, 0, -1, 8'd0, "T_after_space");
  endtask

  task automatic test_invalid();
    send_char(0, 50, 4, 1'b0, 0, -1, 8'd0, "code50");
  endtask

  task automatic test_latched_compare();
    mi.unit_len = 8'd1;
    send_char(0, 4, 1025, 1'b0, 0, 500, 8'd2, "E_latched");
    mi.unit_len = 8'd0;
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0);
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (mi.key_out !== 1'b1 || mi.elem_dash !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_dash_active: key=%b dash=%b, want 1 1", mi.key_out, mi.elem_dash);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mi.key_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: key=%b, want 0", mi.key_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mi.char_ready !== 1'b1 || mi.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: ready=%b busy=%b, want 1 0", mi.char_ready, mi.busy);
    end
    send_char(0, 4, 4, 1'b0, 0, -1, 8'd0, "E_after_reset");
  endtask

  task automatic test_zero_compare();
    send_char(1, 0, 1, 1'b0, 0, -1, 8'd0, "A_cmp0");
    send_char(1, 36, 1, 1'b0, 0, -1, 8'd0, "space_cmp0");
    send_char(1, 63, 1, 1'b0, 0, -1, 8'd0, "code63_cmp0");
  endtask

  task automatic test_random();
    int code, nxt;
    bit hold;
    for (int sel = 0; sel < 2; sel++) begin
      code = int'($urandom_range(0, 63));
      for (int i = 0; i < 12; i++) begin
        nxt  = int'($urandom_range(0, 63));
        hold = (code <= 36) && (i != 11) && ($urandom_range(0, 1) == 1);
        send_char(sel, code, sel != 0 ? 1 : 4, hold, nxt, -1, 8'd0, $sformatf("rand%0d_%0d_c%0d", sel, i, code));
        code = nxt;
      end
      drive(sel, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_letters();
    test_back_to_back();
    test_invalid();
    test_latched_compare();
    test_reset_mid();
    test_zero_compare();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
